// File: rtl/expgob_dec_pkg.sv
// expgob_pkg: types and constants shared by the exp_gob encoder and expgob_dec decoder
package expgob_pkg;
  typedef enum logic {PREFIX, SUFFIX} state_t;
  localparam int EXPGOB_DATA_W = 8;
  localparam int EXPGOB_MAX_Z = EXPGOB_DATA_W;
endpackage

// File: rtl/expgob_dec_if.sv
// expgob_dec_if: codeword bit stream in, decoded value out; master is the environment, slave is the decoder
interface expgob_dec_if import expgob_pkg::*; #(
  parameter int DATA_W = EXPGOB_DATA_W
);
  logic bit_i;
  logic bit_vld_i;
  logic bit_rdy_o;
  logic [DATA_W-1:0] dt_o;
  logic dt_vld_o;
  logic dt_rdy_i;
  logic busy_o;
  logic err_o;
  modport master (
    output bit_i, bit_vld_i, dt_rdy_i,
    input bit_rdy_o, dt_o, dt_vld_o, busy_o, err_o
  );
  modport slave (
    input bit_i, bit_vld_i, dt_rdy_i,
    output bit_rdy_o, dt_o, dt_vld_o, busy_o, err_o
  );
endinterface

// File: rtl/expgob_dec.sv
// expgob_dec: serial order-0 Exp-Golomb decoder with valid/ready result register
// EXPGOB_DEC_ERR_EN: flag prefixes longer than DATA_W zeros instead of saturating
module expgob_dec import expgob_pkg::*; #(
  parameter int DATA_W = EXPGOB_DATA_W
) (
  input logic clk,
  input logic rst_n,
  expgob_dec_if.slave bus
);
  localparam int ZW = $clog2(DATA_W + 1);
  localparam logic [ZW-1:0] MAX_Z = ZW'(DATA_W);
  state_t state, state_n;
  logic [ZW-1:0] zcnt, zcnt_n, rem, rem_n;
  logic [DATA_W:0] acc, acc_n;
  logic [DATA_W-1:0] dt, dt_n;
  logic vld, vld_n, err, err_n, take;
  assign bus.bit_rdy_o = !vld || bus.dt_rdy_i;
  assign take = bus.bit_vld_i && bus.bit_rdy_o;
  assign bus.dt_o = dt;
  assign bus.dt_vld_o = vld;
  assign bus.err_o = err;
  assign bus.busy_o = (state == SUFFIX) || (zcnt != '0);
  always_comb begin
    state_n = state;
    zcnt_n = zcnt;
    rem_n = rem;
    acc_n = acc;
    dt_n = dt;
    err_n = 1'b0;
    vld_n = vld && !bus.dt_rdy_i;
    if (take && state == PREFIX) begin
      if (!bus.bit_i) begin
`ifdef EXPGOB_DEC_ERR_EN
        err_n = zcnt == MAX_Z;
        zcnt_n = err_n ? '0 : zcnt + 1'b1;
        acc_n = err_n ? '0 : acc;
        rem_n = err_n ? '0 : rem;
`else
        zcnt_n = zcnt == MAX_Z ? zcnt : zcnt + 1'b1;
`endif
      end else if (zcnt == '0) begin
        dt_n = '0;
        vld_n = 1'b1;
      end else begin
        acc_n = (DATA_W+1)'(1);
        rem_n = zcnt;
        state_n = SUFFIX;
      end
    end else if (take) begin
      acc_n = (DATA_W+1)'({acc, bus.bit_i});
      rem_n = rem - 1'b1;
      if (rem == ZW'(1)) begin
        // acc holds n+1 with its implicit leading one, so n+1 >= 1 and the subtraction cannot wrap
        dt_n = DATA_W'(acc_n - 1'b1);
        vld_n = 1'b1;
        zcnt_n = '0;
        state_n = PREFIX;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PREFIX;
      zcnt <= '0;
      rem <= '0;
      acc <= '0;
      dt <= '0;
      vld <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      zcnt <= zcnt_n;
      rem <= rem_n;
      acc <= acc_n;
      dt <= dt_n;
      vld <= vld_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_expgob_dec.sv
// tb_expgob_dec: directed self-checking bench for expgob_dec (DATA_W = 8)
module tb_expgob_dec;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  expgob_dec_if #(.DATA_W(8)) bus();
  expgob_dec #(.DATA_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  // every task starts and ends just after a falling edge
  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      bus.bit_vld_i = 1'b0;
      bus.bit_i = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.bit_i = b;
    bus.bit_vld_i = 1'b1;
    @(negedge clk);
    bus.bit_vld_i = 1'b0;
  endtask

  task automatic send_code(input int n, input int max_gap);
    logic [8:0] v;
    int l;
    v = 9'(n + 1);
    l = 0;
    for (int i = 0; i < 9; i++) if (v[i]) l = i;
    repeat (l) send_bit(1'b0, $urandom_range(0, max_gap));
    for (int i = l; i >= 0; i--) send_bit(v[i], $urandom_range(0, max_gap));
  endtask

  task automatic test_reset;
    checks++;
    if ({bus.bit_rdy_o, bus.dt_vld_o, bus.busy_o, bus.err_o, bus.dt_o} !== {4'b1000, 8'h00}) begin
      errors++;
      $display("FAIL reset_held: got %b expected %b", {bus.bit_rdy_o, bus.dt_vld_o, bus.busy_o, bus.err_o, bus.dt_o}, {4'b1000, 8'h00});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.bit_rdy_o, bus.dt_vld_o, bus.busy_o, bus.err_o, bus.dt_o} !== {4'b1000, 8'h00}) begin
      errors++;
      $display("FAIL reset_released: got %b expected %b", {bus.bit_rdy_o, bus.dt_vld_o, bus.busy_o, bus.err_o, bus.dt_o}, {4'b1000, 8'h00});
    end
  endtask

  task automatic test_single;
    send_bit(1'b1, 0);
    checks++;
    if ({bus.dt_vld_o, bus.dt_o, bus.busy_o} !== {1'b1, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL single_one: got vld=%b dt=%0d busy=%b expected vld=1 dt=0 busy=0", bus.dt_vld_o, bus.dt_o, bus.busy_o);
    end
    @(negedge clk);
    checks++;
    if (bus.dt_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL single_consumed: got vld=%b expected 0", bus.dt_vld_o);
    end
  endtask

  task automatic test_back_to_back;
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    checks++;
    if ({bus.dt_vld_o, bus.dt_o} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL b2b_first: got vld=%b dt=%0d expected vld=1 dt=1", bus.dt_vld_o, bus.dt_o);
    end
    send_bit(1'b0, 0);
    checks++;
    if ({bus.dt_vld_o, bus.busy_o} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_gap: got vld=%b busy=%b expected vld=0 busy=1", bus.dt_vld_o, bus.busy_o);
    end
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    checks++;
    if ({bus.dt_vld_o, bus.dt_o} !== {1'b1, 8'd6}) begin
      errors++;
      $display("FAIL b2b_second: got vld=%b dt=%0d expected vld=1 dt=6", bus.dt_vld_o, bus.dt_o);
    end
    @(negedge clk);
  endtask

  task automatic test_max;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b0, 0);
      checks++;
      if (bus.busy_o !== 1'b1) begin
        errors++;
        $display("FAIL max_busy_prefix%0d: got %b expected 1", i, bus.busy_o);
      end
    end
    send_bit(1'b1, 0);
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b0, 0);
      if (i < 7) begin
        checks++;
        if ({bus.busy_o, bus.dt_vld_o} !== 2'b10) begin
          errors++;
          $display("FAIL max_busy_suffix%0d: got busy=%b vld=%b expected busy=1 vld=0", i, bus.busy_o, bus.dt_vld_o);
        end
      end
    end
    checks++;
    if ({bus.dt_vld_o, bus.dt_o, bus.busy_o} !== {1'b1, 8'd255, 1'b0}) begin
      errors++;
      $display("FAIL max_value: got vld=%b dt=%0d busy=%b expected vld=1 dt=255 busy=0", bus.dt_vld_o, bus.dt_o, bus.busy_o);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bus.dt_rdy_i = 1'b0;
    send_code(2, 0);
    checks++;
    if ({bus.dt_vld_o, bus.dt_o, bus.bit_rdy_o} !== {1'b1, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL bp_result: got vld=%b dt=%0d rdy=%b expected vld=1 dt=2 rdy=0", bus.dt_vld_o, bus.dt_o, bus.bit_rdy_o);
    end
    bus.bit_i = 1'b1;
    bus.bit_vld_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bus.dt_vld_o, bus.dt_o, bus.bit_rdy_o, bus.busy_o} !== {1'b1, 8'd2, 2'b00}) begin
        errors++;
        $display("FAIL bp_stall: got vld=%b dt=%0d rdy=%b busy=%b expected vld=1 dt=2 rdy=0 busy=0", bus.dt_vld_o, bus.dt_o, bus.bit_rdy_o, bus.busy_o);
      end
    end
    bus.dt_rdy_i = 1'b1;
    #1;
    checks++;
    if (bus.bit_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_rdy_comb: got %b expected 1", bus.bit_rdy_o);
    end
    @(negedge clk);
    checks++;
    if ({bus.dt_vld_o, bus.dt_o} !== {1'b1, 8'd0}) begin
      errors++;
      $display("FAIL bp_overlap: got vld=%b dt=%0d expected vld=1 dt=0", bus.dt_vld_o, bus.dt_o);
    end
    bus.bit_vld_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dt_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got vld=%b expected 0", bus.dt_vld_o);
    end
  endtask

  task automatic test_malformed;
`ifdef EXPGOB_DEC_ERR_EN
    for (int i = 0; i < 8; i++) send_bit(1'b0, 0);
    checks++;
    if (bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_early: got %b expected 0", bus.err_o);
    end
    send_bit(1'b0, 0);
    checks++;
    if ({bus.err_o, bus.dt_vld_o, bus.busy_o} !== 3'b100) begin
      errors++;
      $display("FAIL err_pulse: got err=%b vld=%b busy=%b expected err=1 vld=0 busy=0", bus.err_o, bus.dt_vld_o, bus.busy_o);
    end
    @(negedge clk);
    checks++;
    if (bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_one_cycle: got %b expected 0", bus.err_o);
    end
    send_bit(1'b1, 0);
    checks++;
    if ({bus.dt_vld_o, bus.dt_o} !== {1'b1, 8'd0}) begin
      errors++;
      $display("FAIL err_recover: got vld=%b dt=%0d expected vld=1 dt=0", bus.dt_vld_o, bus.dt_o);
    end
`else
    for (int i = 0; i < 9; i++) begin
      send_bit(1'b0, 0);
      checks++;
      if ({bus.err_o, bus.busy_o} !== 2'b01) begin
        errors++;
        $display("FAIL sat_prefix%0d: got err=%b busy=%b expected err=0 busy=1", i, bus.err_o, bus.busy_o);
      end
    end
    send_bit(1'b1, 0);
    for (int i = 0; i < 8; i++) send_bit(1'b0, 0);
    checks++;
    if ({bus.dt_vld_o, bus.dt_o, bus.err_o} !== {1'b1, 8'd255, 1'b0}) begin
      errors++;
      $display("FAIL sat_value: got vld=%b dt=%0d err=%b expected vld=1 dt=255 err=0", bus.dt_vld_o, bus.dt_o, bus.err_o);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    send_code(6, 0);
    @(negedge clk);
    repeat (3) send_bit(1'b0, 0);
    checks++;
    if ({bus.busy_o, bus.dt_o} !== {1'b1, 8'd6}) begin
      errors++;
      $display("FAIL mid_before: got busy=%b dt=%0d expected busy=1 dt=6", bus.busy_o, bus.dt_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.bit_rdy_o, bus.dt_vld_o, bus.busy_o, bus.err_o, bus.dt_o} !== {4'b1000, 8'h00}) begin
      errors++;
      $display("FAIL mid_reset: got %b expected %b", {bus.bit_rdy_o, bus.dt_vld_o, bus.busy_o, bus.err_o, bus.dt_o}, {4'b1000, 8'h00});
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_code(1, 0);
    checks++;
    if ({bus.dt_vld_o, bus.dt_o} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL mid_after: got vld=%b dt=%0d expected vld=1 dt=1", bus.dt_vld_o, bus.dt_o);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep;
    for (int n = 0; n < 256; n++) begin
      send_code(n, 2);
      checks++;
      if ({bus.dt_vld_o, bus.dt_o} !== {1'b1, 8'(n)}) begin
        errors++;
        $display("FAIL sweep_n%0d: got vld=%b dt=%0d expected vld=1 dt=%0d", n, bus.dt_vld_o, bus.dt_o, n);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bus.bit_i = 1'b0;
    bus.bit_vld_i = 1'b0;
    bus.dt_rdy_i = 1'b1;
    repeat (2) @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_max;
    test_backpressure;
    test_malformed;
    test_reset_mid;
    test_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/expgob_dec.md
# expgob_dec

Serial Exp-Golomb (order k = 0) decoder that sits directly downstream of the `exp_gob` encoder. It consumes the encoder's one-bit-per-cycle codeword stream and reconstructs the unsigned value. It presents each value on a registered output behind a valid/ready handshake. Input bits are stalled while a decoded result is still pending.

## Interface
- `DATA_W`, default 8: width of decoded value. Maximum prefix zeros = `DATA_W`; accumulator width = `DATA_W+1`.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `bit_i`  in  1  codeword bit, MSB first (prefix zeros, then binary of n+1).
- `bit_vld_i`  in  1  `bit_i` is valid this cycle.
- `bit_rdy_o`  out  1  decoder accepts `bit_i`; a bit is consumed only when `bit_vld_i && bit_rdy_o`.
- `dt_o`  out  `DATA_W`  decoded value n.
- `dt_vld_o`  out  1  `dt_o` valid; held until accepted.
- `dt_rdy_i`  in  1  downstream accepts `dt_o`.
- `busy_o`  out  1  a codeword is partially received.
- `err_o`  out  1  one-cycle pulse on malformed codeword (see Configuration).

## Operation
- FSM states, in `expgob_pkg::state_t`:
  - `PREFIX` (reset state).
  - `SUFFIX`.
- `PREFIX`, accepted bit = 0:
  - `zcnt <= zcnt+1`.
  - `busy_o` set.
- `PREFIX`, accepted bit = 1, with `zcnt==0`:
  - Codeword "1" → n = 0.
  - Result registered immediately; stay in `PREFIX`.
- `PREFIX`, accepted bit = 1, with `zcnt>0`:
  - `acc <= 1`, `rem <= zcnt`.
  - Go to `SUFFIX`.
- `SUFFIX`, each accepted bit:
  - `acc <= {acc, bit_i}`, `rem <= rem-1`.
  - When `rem==1` (last suffix bit): register `dt_o <= {acc,bit_i} - 1`, truncated to `DATA_W`.
  - Clear `zcnt`; go to `PREFIX`.
- Arithmetic: `acc` is `DATA_W+1` bits. Value n+1 ranges 1..2^DATA_W, so the subtraction never underflows.
- Result register:
  - Registering a result sets `dt_vld_o`.
  - `dt_vld_o` clears on `dt_vld_o && dt_rdy_i`, unless a new result is registered in the same cycle; the new result wins.
- `bit_rdy_o = !dt_vld_o || dt_rdy_i` (combinational). This guarantees a pending result is never overwritten.
- `busy_o = (state==SUFFIX) || (zcnt!=0)`.
- `bit_vld_i` low: no state change in any state; gaps inside a codeword are legal.

## Timing
- Reset values:
  - `dt_o`=0, `dt_vld_o`=0, `busy_o`=0, `err_o`=0, `bit_rdy_o`=1.
  - State `PREFIX`, `zcnt`=0, `acc`=0, `rem`=0.
- Latency: `dt_vld_o` rises the cycle after the final codeword bit is accepted.
- Codeword length for value n: 2·⌊log2(n+1)⌋+1 accepted bits, up to 17 for `DATA_W`=8.
- Back-to-back codewords need no idle cycles when `dt_rdy_i` is held high.
- Simultaneous accept of old result and completion of a new one in the same cycle:
  - `dt_vld_o` stays 1.
  - `dt_o` takes the new value.
- Reset asserted mid-codeword: partial codeword discarded; all registers go to their reset values asynchronously.
- `err_o`: registered, high for exactly one cycle.

## Configuration
- Macro: `EXPGOB_DEC_ERR_EN`.
- Defined:
  - Accepting a zero while `zcnt==DATA_W` is a malformed codeword.
  - `err_o` pulses the next cycle.
  - `zcnt`, `acc` and `rem` clear; state returns to `PREFIX`.
  - No result is produced.
- Undefined:
  - `err_o` is tied 0.
  - `zcnt` saturates at `DATA_W`; extra prefix zeros are ignored.
  - The following suffix is decoded as a `DATA_W+1`-bit suffix.

## Structure
- `expgob_pkg` holds:
  - `state_t` enum {`PREFIX`, `SUFFIX`}.
  - `EXPGOB_DATA_W` = 8.
  - `EXPGOB_MAX_Z` = `EXPGOB_DATA_W`.
  - Shared with the encoder.
- Single module `expgob_dec`; no sub-module needed.

## Test plan
- Stream "1" with `dt_rdy_i`=1 → next cycle `dt_vld_o`=1, `dt_o`=0, `busy_o`=0 throughout.
- Stream "010" then "00111" back-to-back → `dt_o`=1, then `dt_o`=6, each valid for one cycle, no idle gap required.
- Stream 8 zeros + "100000000" → `dt_o`=255; `busy_o` high from the first bit until the result is registered.
- Sweep n=0..255 encoded by `exp_gob`, with random `bit_vld_i` gaps → every `dt_o` equals n, in order.
- Backpressure:
  - Hold `dt_rdy_i`=0 after a result → `bit_rdy_o`=0, `dt_o` stable, no input bits consumed.
  - Raise `dt_rdy_i` → accepted, and `bit_rdy_o`=1 in the same cycle.
- Malformed prefix and reset:
  - With `EXPGOB_DEC_ERR_EN`: 9 zeros → `err_o` one-cycle pulse, no `dt_vld_o`; a following "1" decodes to 0.
  - Assert `rst_n`=0 after 3 zeros → all outputs at reset values immediately.
